// File: rtl/serial_sub16.sv
// serial_sub16: nibble-serial 16-bit A - B over four cycles with signed-overflow and zero flags.
// Optional build macro SERIAL_SUB16_SATURATE_EN clamps Diff to 0x7FFF/0x8000 on overflow.
module serial_sub16 (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] A,
   input  logic [15:0] B,
   output logic        busy,
   output logic        done,
   output logic [15:0] Diff,
   output logic        Error,
   output logic        Zero
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic        c_q, c_d;
   logic [15:0] ar_q, ar_d, br_q, br_d, p_q, p_d, diff_q, diff_d;
   logic        err_q, err_d, zero_q, zero_d;
   logic [4:0]  sum;
   logic [15:0] p_n, res;
   logic        ovf;
   // state, operand, borrow-chain and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= 2'd0;
         c_q     <= 1'b0;
         ar_q    <= 16'h0000;
         br_q    <= 16'h0000;
         p_q     <= 16'h0000;
         diff_q  <= 16'h0000;
         err_q   <= 1'b0;
         zero_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         c_q     <= c_d;
         ar_q    <= ar_d;
         br_q    <= br_d;
         p_q     <= p_d;
         diff_q  <= diff_d;
         err_q   <= err_d;
         zero_q  <= zero_d;
      end
   end
   // one nibble of A + ~B + c per RUN cycle; results published only on the last nibble
   always_comb begin
      sum = {1'b0, ar_q[{idx_q, 2'b00} +: 4]} + {1'b0, ~br_q[{idx_q, 2'b00} +: 4]} + {4'd0, c_q};
      p_n = p_q;
      p_n[{idx_q, 2'b00} +: 4] = sum[3:0];
      ovf = (ar_q[15] ^ br_q[15]) & (p_n[15] ^ ar_q[15]);
`ifdef SERIAL_SUB16_SATURATE_EN
      res = ovf ? (ar_q[15] ? 16'h8000 : 16'h7fff) : p_n;
`else
      res = p_n;
`endif
      state_d = state_q;
      idx_d   = idx_q;
      c_d     = c_q;
      ar_d    = ar_q;
      br_d    = br_q;
      p_d     = p_q;
      diff_d  = diff_q;
      err_d   = err_q;
      zero_d  = zero_q;
      if (state_q == RUN) begin
         p_d   = p_n;
         c_d   = sum[4];
         idx_d = idx_q + 2'd1;
         if (idx_q == 2'd3) begin
            state_d = DONE;
            diff_d  = res;
            err_d   = ovf;
            zero_d  = (res == 16'h0000);
         end
      end else if (start) begin
         state_d = RUN;
         ar_d    = A;
         br_d    = B;
         idx_d   = 2'd0;
         c_d     = 1'b1;
         p_d     = 16'h0000;
      end else begin
         state_d = IDLE;
      end
   end
   assign busy  = (state_q == RUN);
   assign done  = (state_q == DONE);
   assign Diff  = diff_q;
   assign Error = err_q;
   assign Zero  = zero_q;
endmodule

// File: tb/tb_serial_sub16.sv
// tb_serial_sub16: randomized and directed checks of serial_sub16 against an arithmetic model.
module tb_serial_sub16;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [15:0] A = 16'h0000, B = 16'h0000;
   logic        busy, done, Error, Zero;
   logic [15:0] Diff;
   int          tests = 0, fails = 0;
   int          cnt = 0;
   logic        m_done = 1'b0, m_err = 1'b0, m_zero = 1'b1;
   logic [15:0] m_diff = 16'h0000;
   logic [17:0] pend = 18'd0;
   int          n;

   serial_sub16 dut (
      .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
      .busy(busy), .done(done), .Diff(Diff), .Error(Error), .Zero(Zero)
   );

   always #5 clk = ~clk;

   // {err, zero, diff} of a - b from signed integer arithmetic
   function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b);
      int          d;
      logic [31:0] du;
      logic        ov;
      logic [15:0] r;
      d  = int'($signed(a)) - int'($signed(b));
      du = d;
      ov = (d > 32767) || (d < -32768);
      r  = du[15:0];
`ifdef SERIAL_SUB16_SATURATE_EN
      if (ov) r = (d > 0) ? 16'h7fff : 16'h8000;
`endif
      return {ov, r == 16'h0000, r};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // timeline model: four busy cycles after acceptance, then one done cycle
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt = 0; m_done = 1'b0; m_diff = 16'h0000; m_err = 1'b0; m_zero = 1'b1;
      end else begin
         m_done = 1'b0;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               m_done = 1'b1;
               {m_err, m_zero, m_diff} = pend;
            end
         end else if (start) begin
            cnt  = 4;
            pend = model(A, B);
         end
      end
   end

   // every-cycle comparison against the model
   always @(negedge clk) begin
      if ($time > 2) begin
         chk("busy", {31'd0, busy}, {31'd0, cnt > 0});
         chk("done", {31'd0, done}, {31'd0, m_done});
         chk("diff", {16'd0, Diff}, {16'd0, m_diff});
         chk("error", {31'd0, Error}, {31'd0, m_err});
         chk("zero", {31'd0, Zero}, {31'd0, m_zero});
      end
   end

   task automatic wait_done();
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 12);
   endtask

   task automatic run_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] ed, input logic ee, input logic ez);
      @(posedge clk); #2;
      A = a; B = b; start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      wait_done();
      chk({nm, " latency"}, n, 5);
      chk({nm, " diff"}, {16'd0, Diff}, {16'd0, ed});
      chk({nm, " error"}, {31'd0, Error}, {31'd0, ee});
      chk({nm, " zero"}, {31'd0, Zero}, {31'd0, ez});
   endtask

   function automatic logic [15:0] pick();
      case ($urandom_range(0, 7))
         0: return 16'h0000;
         1: return 16'h0001;
         2: return 16'h7fff;
         3: return 16'h8000;
         4: return 16'hffff;
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      #1 rst = 1'b1;
      #2;
      chk("reset busy", {31'd0, busy}, 0);
      chk("reset done", {31'd0, done}, 0);
      chk("reset diff", {16'd0, Diff}, 0);
      chk("reset error", {31'd0, Error}, 0);
      chk("reset zero", {31'd0, Zero}, 1);
      @(posedge clk); #2 rst = 1'b0;
      run_op("basic", 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0);
      run_op("borrow", 16'h1000, 16'h0001, 16'h0fff, 1'b0, 1'b0);
`ifdef SERIAL_SUB16_SATURATE_EN
      run_op("neg ovf", 16'h8000, 16'h0001, 16'h8000, 1'b1, 1'b0);
      run_op("pos ovf", 16'h7fff, 16'hffff, 16'h7fff, 1'b1, 1'b0);
`else
      run_op("neg ovf", 16'h8000, 16'h0001, 16'h7fff, 1'b1, 1'b0);
      run_op("pos ovf", 16'h7fff, 16'hffff, 16'h8000, 1'b1, 1'b0);
`endif
      run_op("equal", 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1);
      @(posedge clk); #2;
      A = 16'h0010; B = 16'h0020; start = 1'b1;
      wait_done();
      chk("b2b first diff", {16'd0, Diff}, 32'h0000fff0);
      wait_done();
      start = 1'b0;
      chk("b2b spacing", n, 5);
      chk("b2b second diff", {16'd0, Diff}, 32'h0000fff0);
      @(posedge clk); #2;
      A = 16'h1111; B = 16'h0011; start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
      @(posedge clk); #2;
      A = 16'hffff; B = 16'h7777; start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
      wait_done();
      chk("ignore start diff", {16'd0, Diff}, 32'h00001100);
      @(posedge clk); #2;
      A = 16'h4321; B = 16'h0001; start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
      @(posedge clk);
      @(posedge clk); #2 rst = 1'b1;
      #1;
      chk("midrst busy", {31'd0, busy}, 0);
      chk("midrst diff", {16'd0, Diff}, 0);
      chk("midrst zero", {31'd0, Zero}, 1);
      chk("midrst done", {31'd0, done}, 0);
      @(posedge clk); #2 rst = 1'b0;
      n = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) n++;
      end
      chk("midrst no done", n, 0);
      for (int i = 0; i < 600; i++) begin
         @(posedge clk); #2;
         start = ($urandom_range(0, 2) == 0);
         A = pick();
         B = pick();
         rst = ($urandom_range(0, 120) == 0);
      end
      @(posedge clk); #2;
      rst = 1'b0; start = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
